// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_skew_feeder
// Brief    : Pulls rows from the upstream shift FIFO and skews byte lane k by
//            k cycles to form the diagonal wavefront for the systolic array.
// Options  : SKEW_ZERO_FILL_EN - force invalid output lanes to 8'h00.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_skew_feeder #(
    parameter int ROWS  = 256,
    parameter int LANES = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 fifo_en,
    input  logic [LANES*8-1:0]   din,
    output logic [LANES*8-1:0]   dout,
    output logic [LANES-1:0]     out_valid,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0]  S_IDLE       = 2'd0;
    localparam logic [1:0]  S_STREAM     = 2'd1;
    localparam logic [1:0]  S_DRAIN      = 2'd2;
    localparam logic [15:0] c_last_row   = 16'(ROWS - 1);
    localparam logic [3:0]  c_last_drain = 4'd14;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [15:0] r_row_cnt;
    logic [3:0]  r_drain_cnt;
    logic        r_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start)                       w_next_state = S_STREAM;
            S_STREAM: if (r_row_cnt == c_last_row)     w_next_state = S_DRAIN;
            S_DRAIN:  if (r_drain_cnt == c_last_drain) w_next_state = S_IDLE;
            default:                                   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_en = (r_state == S_STREAM);
        busy    = (r_state != S_IDLE);
        done    = r_done;
    end

    // Counters are held at zero outside their own state, so entry clears them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row_cnt   <= 16'd0;
            r_drain_cnt <= 4'd0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == S_DRAIN) && (r_drain_cnt == c_last_drain);
            case (r_state)
                S_STREAM: begin
                    r_row_cnt   <= r_row_cnt + 16'd1;
                    r_drain_cnt <= 4'd0;
                end
                S_DRAIN: begin
                    r_row_cnt   <= 16'd0;
                    r_drain_cnt <= r_drain_cnt + 4'd1;
                end
                default: begin
                    r_row_cnt   <= 16'd0;
                    r_drain_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Lane k is a (k+1)-deep byte+valid shift register fed from din lane k.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [7:0] r_byte [0:k];
        logic       r_vld  [0:k];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int s = 0; s <= k; s++) begin
                    r_byte[s] <= 8'h00;
                    r_vld[s]  <= 1'b0;
                end
            end else begin
                r_byte[0] <= fifo_en ? din[8*k +: 8] : 8'h00;
                r_vld[0]  <= fifo_en;
                for (int s = 1; s <= k; s++) begin
                    r_byte[s] <= r_byte[s-1];
                    r_vld[s]  <= r_vld[s-1];
                end
            end
        end

`ifdef SKEW_ZERO_FILL_EN
        assign dout[8*k +: 8] = r_vld[k] ? r_byte[k] : 8'h00;
`else
        assign dout[8*k +: 8] = r_byte[k];
`endif
        assign out_valid[k] = r_vld[k];
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_skew_feeder
// Brief    : Scoreboard bench for systolic_skew_feeder with ROWS=4 and ROWS=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_skew_feeder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   start;
    logic [127:0] din;
    logic [1:0]   fifo_en;
    logic [1:0]   busy;
    logic [1:0]   done;
    logic [127:0] dout      [2];
    logic [15:0]  out_valid [2];

    always #5 clk = ~clk;

    systolic_skew_feeder #(.ROWS(4), .LANES(16)) u_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start[0]),
        .fifo_en   (fifo_en[0]),
        .din       (din),
        .dout      (dout[0]),
        .out_valid (out_valid[0]),
        .busy      (busy[0]),
        .done      (done[0])
    );

    systolic_skew_feeder #(.ROWS(1), .LANES(16)) u_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start[1]),
        .fifo_en   (fifo_en[1]),
        .din       (din),
        .dout      (dout[1]),
        .out_valid (out_valid[1]),
        .busy      (busy[1]),
        .done      (done[1])
    );

    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    int           s_edge  [2];
    int           rows_of [2] = '{4, 1};
    int           fen_cnt [2];
    logic [8:0]   q [2][16][$];

    // Frame timing measured in edges after the start-accept edge.
    function automatic bit m_stream(int i, int c);
        return (c >= s_edge[i]) && (c < s_edge[i] + rows_of[i]);
    endfunction

    function automatic bit m_busy(int i, int c);
        return (c >= s_edge[i]) && (c < s_edge[i] + rows_of[i] + 15);
    endfunction

    function automatic bit m_done(int i, int c);
        return c == s_edge[i] + rows_of[i] + 15;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            s_edge[i] = -1000;
            for (int k = 0; k < 16; k++) begin
                q[i][k].delete();
                for (int j = 0; j < k; j++) q[i][k].push_back(9'd0);
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s u%0d fifo_en", tag, i), 32'(fifo_en[i]), 32'd0);
            chk($sformatf("%s u%0d busy", tag, i), 32'(busy[i]), 32'd0);
            chk($sformatf("%s u%0d done", tag, i), 32'(done[i]), 32'd0);
            chk($sformatf("%s u%0d out_valid", tag, i), 32'(out_valid[i]), 32'd0);
            for (int k = 0; k < 16; k++)
                chk($sformatf("%s u%0d dout lane%0d", tag, i, k), 32'(dout[i][8*k +: 8]), 32'd0);
        end
    endtask

    task automatic tick();
        bit         acc [2];
        logic [8:0] e;
        for (int i = 0; i < 2; i++) begin
            acc[i] = start[i] && !m_busy(i, cyc);
            if (fifo_en[i] === 1'b1) fen_cnt[i]++;
            for (int k = 0; k < 16; k++)
                q[i][k].push_back(m_stream(i, cyc) ? {1'b1, din[8*k +: 8]} : 9'd0);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!reset_n) begin
            model_reset();
            check_zero("in_reset");
        end else begin
            for (int i = 0; i < 2; i++)
                if (acc[i]) s_edge[i] = cyc;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("c%0d u%0d fifo_en", cyc, i), 32'(fifo_en[i]), 32'(m_stream(i, cyc)));
                chk($sformatf("c%0d u%0d busy", cyc, i), 32'(busy[i]), 32'(m_busy(i, cyc)));
                chk($sformatf("c%0d u%0d done", cyc, i), 32'(done[i]), 32'(m_done(i, cyc)));
                for (int k = 0; k < 16; k++) begin
                    e = q[i][k].pop_front();
                    chk($sformatf("c%0d u%0d lane%0d data", cyc, i, k), 32'(dout[i][8*k +: 8]), 32'(e[7:0]));
                    chk($sformatf("c%0d u%0d lane%0d valid", cyc, i, k), 32'(out_valid[i][k]), 32'(e[8]));
                end
            end
        end
    endtask

    task automatic wait_done(int i, int s, int exp_lat, string tag);
        int lat;
        lat = -1;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (done[i] === 1'b1) begin
                lat = cyc - s;
                break;
            end
        end
        chk(tag, 32'(lat), 32'(exp_lat));
    endtask

    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_zero("async_rst");
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int s;
        int dcount;
        reset_n = 1'b0;
        start   = 2'b00;
        din     = '0;
        fen_cnt = '{0, 0};
        model_reset();
        #2;
        check_zero("por");
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (20) tick();

        // ROWS=4 frame with row r = all bytes 8'h10+r.
        fen_cnt[0] = 0;
        start[0] = 1'b1;
        tick();
        s = cyc;
        start[0] = 1'b0;
        for (int r = 0; r < 4; r++) begin
            din = {16{8'(8'h10 + r)}};
            tick();
        end
        din = {16{8'hFF}};
        wait_done(0, s, 19, "a_done_latency");
        chk("a_fifo_en_cycles", 32'(fen_cnt[0]), 32'd4);
        repeat (3) tick();

        // ROWS=1 frame with lane index as data.
        fen_cnt[1] = 0;
        start[1] = 1'b1;
        tick();
        s = cyc;
        start[1] = 1'b0;
        for (int k = 0; k < 16; k++) din[8*k +: 8] = 8'(k);
        tick();
        din = {16{8'hFF}};
        wait_done(1, s, 16, "b_done_latency");
        chk("b_fifo_en_cycles", 32'(fen_cnt[1]), 32'd1);
        repeat (3) tick();

        // Starts during STREAM and DRAIN must be dropped.
        start[0] = 1'b1;
        tick();
        s = cyc;
        start[0] = 1'b0;
        for (int r = 0; r < 4; r++) begin
            din = {16{8'(8'h20 + r)}};
            start[0] = (r == 1);
            tick();
            start[0] = 1'b0;
        end
        din = {16{8'hFF}};
        repeat (5) tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        wait_done(0, s, 19, "a_ignored_start_latency");

        // Start in the done cycle launches the next frame immediately.
        start[0] = 1'b1;
        tick();
        s = cyc;
        start[0] = 1'b0;
        chk("a_b2b_fifo_en", 32'(fifo_en[0]), 32'd1);
        for (int r = 0; r < 4; r++) begin
            din = {16{8'(8'h30 + r)}};
            tick();
        end
        din = {16{8'hFF}};
        wait_done(0, s, 19, "a_b2b_latency");

        // Asynchronous reset in the middle of STREAM.
        repeat (2) tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        din = {16{8'h40}};
        tick();
        din = {16{8'h41}};
        tick();
        async_reset();
        din = {16{8'hFF}};
        dcount = 0;
        for (int n = 0; n < 25; n++) begin
            tick();
            if (done[0] === 1'b1) dcount++;
        end
        chk("a_no_done_after_reset", 32'(dcount), 32'd0);
        chk("a_idle_after_reset", 32'(busy[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
